// File: rtl/nx_reg_indirect_access_mw.sv
// Multi-word indirect register array behind a CSR command/status/data window.
// Entries are staged through N_DWORDS 32-bit data registers; READ/WRITE/INIT/RESET commands.
module nx_reg_indirect_access_mw #(
    parameter int N_DATA_BITS     = 64,
    parameter int N_ENTRIES       = 32,
    parameter int N_REG_ADDR_BITS = 11,
    parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS = 11'h454,
    parameter logic [N_REG_ADDR_BITS-1:0] STAT_ADDRESS = 11'h44C,
    parameter logic [N_REG_ADDR_BITS-1:0] DATA_ADDRESS = 11'h460,
    localparam int N_DWORDS = (N_DATA_BITS + 31) / 32,
    localparam int AW       = $clog2(N_ENTRIES)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REG_ADDR_BITS-1:0]        addr,
    input  logic                              wr_stb,
    input  logic [31:0]                       wr_dat,
    input  logic [3:0]                        cmnd_op,
    input  logic [AW-1:0]                     cmnd_addr,
    output logic [31:0]                       rd_dat,
    output logic [2:0]                        stat_code,
    output logic [4:0]                        stat_datawords,
    output logic [AW-1:0]                     stat_addr,
    output logic [15:0]                       capability_lst,
    output logic [3:0]                        capability_type,
    input  logic [N_ENTRIES*N_DATA_BITS-1:0]  rst_dat,
    output logic [N_ENTRIES*N_DATA_BITS-1:0]  mem_q
);

    localparam int DW_BITS  = N_DWORDS * 32;
    localparam int MEM_BITS = N_ENTRIES * N_DATA_BITS;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_READ  = 4'd1;
    localparam logic [3:0] OP_WRITE = 4'd2;
    localparam logic [3:0] OP_INIT  = 4'd3;
    localparam logic [3:0] OP_RESET = 4'd4;

    localparam logic [2:0] ST_READY    = 3'd0;
    localparam logic [2:0] ST_BUSY     = 3'd1;
    localparam logic [2:0] ST_ERR_ADDR = 3'd2;
    localparam logic [2:0] ST_ERR_OP   = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [3:0]                     op_q;
    logic [AW-1:0]                  addr_q;
    logic [AW-1:0]                  fill_cnt;
    logic [AW-1:0]                  stat_addr_q;
    logic [2:0]                     code_q;
    logic [2:0]                     exec_code;
    logic [MEM_BITS-1:0]            mem;
    logic [DW_BITS-1:0]             dreg;

    logic                           cmd_accept;
    logic                           data_hit;
    logic                           data_write;
    logic                           addr_ok;
    logic                           fill_last;
    logic [N_REG_ADDR_BITS-1:0]     data_off;
    logic [N_DATA_BITS-1:0]         entry_rd;
    logic [DW_BITS-1:0]             entry_ext;
    logic [31:0]                    status_word;

    // Error states count as idle: only EXEC/FILL block new CSR commands and data writes.
    assign cmd_accept = wr_stb && (addr == CMND_ADDRESS) && (state_q == IDLE);
    assign data_off   = addr - DATA_ADDRESS;
    assign data_hit   = int'(data_off) < N_DWORDS;
    assign data_write = wr_stb && data_hit && (state_q == IDLE);
    assign addr_ok    = int'(addr_q) < N_ENTRIES;
    assign fill_last  = int'(fill_cnt) == (N_ENTRIES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d = (cmnd_op == OP_INIT) ? FILL : EXEC;
                end
            end
            EXEC: state_d = IDLE;
            FILL: begin
                if (fill_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        exec_code = ST_ERR_OP;
        case (op_q)
            OP_NOP, OP_INIT, OP_RESET: exec_code = ST_READY;
            OP_READ, OP_WRITE:         exec_code = addr_ok ? ST_READY : ST_ERR_ADDR;
            default:                   exec_code = ST_ERR_OP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_NOP;
            addr_q      <= '0;
            stat_addr_q <= '0;
            code_q      <= ST_READY;
            fill_cnt    <= '0;
        end else if (cmd_accept) begin
            op_q        <= cmnd_op;
            addr_q      <= cmnd_addr;
            stat_addr_q <= cmnd_addr;
            code_q      <= ST_BUSY;
            fill_cnt    <= '0;
        end else if (state_q == EXEC) begin
            code_q <= exec_code;
        end else if (state_q == FILL) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_last) begin
                code_q <= ST_READY;
            end
        end
    end

    always_comb begin
        entry_rd  = mem[int'(addr_q)*N_DATA_BITS +: N_DATA_BITS];
        entry_ext = '0;
        entry_ext[N_DATA_BITS-1:0] = entry_rd;
    end

    // Bits of the top data word above N_DATA_BITS never reach the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= rst_dat;
        end else if (state_q == EXEC) begin
            if (op_q == OP_WRITE && addr_ok) begin
                mem[int'(addr_q)*N_DATA_BITS +: N_DATA_BITS] <= dreg[N_DATA_BITS-1:0];
            end else if (op_q == OP_RESET) begin
                mem <= rst_dat;
            end
        end else if (state_q == FILL) begin
            mem[int'(fill_cnt)*N_DATA_BITS +: N_DATA_BITS] <= dreg[N_DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dreg <= '0;
        end else if (data_write) begin
            dreg[int'(data_off)*32 +: 32] <= wr_dat;
        end else if (state_q == EXEC && op_q == OP_READ && addr_ok) begin
            dreg <= entry_ext;
        end
    end

    always_comb begin
        status_word          = '0;
        status_word[31:29]   = code_q;
        status_word[28:24]   = stat_datawords;
        status_word[23:20]   = capability_type;
        status_word[AW-1:0]  = stat_addr_q;
        rd_dat = '0;
        if (addr == STAT_ADDRESS) begin
            rd_dat = status_word;
        end else if (data_hit) begin
            rd_dat = dreg[int'(data_off)*32 +: 32];
        end
    end

    assign stat_code       = code_q;
    assign stat_addr       = stat_addr_q;
    assign stat_datawords  = 5'(N_DWORDS);
    assign capability_lst  = 16'h001F;
    assign capability_type = 4'd0;
    assign mem_q           = mem;

endmodule

// File: tb/tb_nx_reg_indirect_access_mw.sv
// Bench for nx_reg_indirect_access_mw: directed scenarios plus randomized command
// traffic checked against an array-level model of the register file.
module tb_nx_reg_indirect_access_mw;

    localparam int NB  = 64;
    localparam int NE  = 32;
    localparam int NE2 = 20;
    localparam logic [10:0] CMND = 11'h454;
    localparam logic [10:0] STAT = 11'h44C;
    localparam logic [10:0] DATA = 11'h460;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;

    logic [10:0]       addr = '0;
    logic              wr_stb = 1'b0;
    logic [31:0]       wr_dat = '0;
    logic [3:0]        cmnd_op = '0;
    logic [4:0]        cmnd_addr = '0;
    logic [31:0]       rd_dat;
    logic [2:0]        stat_code;
    logic [4:0]        stat_datawords;
    logic [4:0]        stat_addr;
    logic [15:0]       capability_lst;
    logic [3:0]        capability_type;
    logic [NE*NB-1:0]  rst_dat;
    logic [NE*NB-1:0]  mem_q;

    logic [10:0]       addr2 = '0;
    logic              wr_stb2 = 1'b0;
    logic [31:0]       wr_dat2 = '0;
    logic [3:0]        cmnd_op2 = '0;
    logic [4:0]        cmnd_addr2 = '0;
    logic [31:0]       rd_dat2;
    logic [2:0]        stat_code2;
    logic [4:0]        stat_datawords2;
    logic [4:0]        stat_addr2;
    logic [15:0]       capability_lst2;
    logic [3:0]        capability_type2;
    logic [NE2*NB-1:0] rst_dat2;
    logic [NE2*NB-1:0] mem_q2;

    int errors = 0;
    int checks = 0;

    logic [63:0] model_mem [NE];
    logic [31:0] model_dreg [2];
    logic [2:0]  model_code;
    logic [4:0]  model_saddr;

    always #5 clk = ~clk;

    nx_reg_indirect_access_mw #(.N_DATA_BITS(NB), .N_ENTRIES(NE)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_stb(wr_stb), .wr_dat(wr_dat),
        .cmnd_op(cmnd_op), .cmnd_addr(cmnd_addr), .rd_dat(rd_dat), .stat_code(stat_code),
        .stat_datawords(stat_datawords), .stat_addr(stat_addr),
        .capability_lst(capability_lst), .capability_type(capability_type),
        .rst_dat(rst_dat), .mem_q(mem_q)
    );

    nx_reg_indirect_access_mw #(.N_DATA_BITS(NB), .N_ENTRIES(NE2)) dut20 (
        .clk(clk), .rst_n(rst_n), .addr(addr2), .wr_stb(wr_stb2), .wr_dat(wr_dat2),
        .cmnd_op(cmnd_op2), .cmnd_addr(cmnd_addr2), .rd_dat(rd_dat2), .stat_code(stat_code2),
        .stat_datawords(stat_datawords2), .stat_addr(stat_addr2),
        .capability_lst(capability_lst2), .capability_type(capability_type2),
        .rst_dat(rst_dat2), .mem_q(mem_q2)
    );

    function automatic logic [63:0] img(int i);
        return {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)};
    endfunction

    function automatic logic [63:0] img2(int i);
        return {32'hB000_0000 + 32'(i), 32'h6000_0000 + 32'(i)};
    endfunction

    function automatic logic [NE*NB-1:0] pack_model();
        logic [NE*NB-1:0] v;
        for (int i = 0; i < NE; i++) v[i*NB +: NB] = model_mem[i];
        return v;
    endfunction

    function automatic int first_bad(input logic [NE*NB-1:0] a, input logic [NE*NB-1:0] b);
        for (int i = 0; i < NE; i++) if (a[i*NB +: NB] !== b[i*NB +: NB]) return i;
        return -1;
    endfunction

    function automatic int first_bad2(input logic [NE2*NB-1:0] a, input logic [NE2*NB-1:0] b);
        for (int i = 0; i < NE2; i++) if (a[i*NB +: NB] !== b[i*NB +: NB]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_status();
        return {model_code, 5'd2, 4'd0, 15'd0, model_saddr};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) model_mem[i] = img(i);
        model_dreg[0] = '0;
        model_dreg[1] = '0;
        model_code    = 3'd0;
        model_saddr   = '0;
    endtask

    // Call only in the low phase of clk; returns at the negedge after the strobe edge.
    task automatic csr_write(input bit sel, input logic [10:0] a, input logic [31:0] d,
                             input logic [3:0] op, input logic [4:0] ca);
        if (sel) begin
            addr2 = a; wr_dat2 = d; cmnd_op2 = op; cmnd_addr2 = ca; wr_stb2 = 1'b1;
        end else begin
            addr = a; wr_dat = d; cmnd_op = op; cmnd_addr = ca; wr_stb = 1'b1;
        end
        @(negedge clk);
        wr_stb = 1'b0; wr_stb2 = 1'b0; addr = '0; addr2 = '0;
        cmnd_op = '0; cmnd_op2 = '0; cmnd_addr = '0; cmnd_addr2 = '0;
    endtask

    task automatic csr_read(input bit sel, input logic [10:0] a, output logic [31:0] d);
        if (sel) addr2 = a; else addr = a;
        #1;
        d = sel ? rd_dat2 : rd_dat;
        addr = '0;
        addr2 = '0;
    endtask

    task automatic wait_ready(input bit sel, output int n);
        n = 0;
        while (((sel ? stat_code2 : stat_code) == 3'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int bad;
        #2 rst_n = 1'b0;
        #1;
        bad = first_bad(mem_q, rst_dat);
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL reset_image entry %0d: got %h want %h", bad, mem_q[bad*NB +: NB], rst_dat[bad*NB +: NB]);
        end
        bad = first_bad2(mem_q2, rst_dat2);
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL reset_image20 entry %0d: got %h want %h", bad, mem_q2[bad*NB +: NB], rst_dat2[bad*NB +: NB]);
        end
        checks++;
        if (stat_code !== 3'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d want 0", stat_code); end
        checks++;
        if (stat_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_saddr: got %0d want 0", stat_addr); end
        checks++;
        if (stat_datawords !== 5'd2) begin errors++; $display("[TB] FAIL datawords: got %0d want 2", stat_datawords); end
        checks++;
        if (capability_lst !== 16'h001F || capability_type !== 4'd0) begin
            errors++;
            $display("[TB] FAIL capability: got %h/%h want 001f/0", capability_lst, capability_type);
        end
        csr_read(0, STAT, rd);
        checks++;
        if (rd[31:29] !== 3'd0) begin errors++; $display("[TB] FAIL reset_stat_field: got %0d want 0", rd[31:29]); end
        checks++;
        if (rd !== 32'h0200_0000) begin errors++; $display("[TB] FAIL reset_stat_word: got %h want 02000000", rd); end
        for (int k = 0; k < 2; k++) begin
            csr_read(0, DATA + 11'(k), rd);
            checks++;
            if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_dreg%0d: got %h want 0", k, rd); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_write();
        int n;
        logic [31:0] rd;
        csr_write(0, DATA, 32'hDEAD_BEEF, 4'd0, 5'd0);
        csr_write(0, DATA + 11'd1, 32'h0123_4567, 4'd0, 5'd0);
        model_dreg[0] = 32'hDEAD_BEEF;
        model_dreg[1] = 32'h0123_4567;
        csr_write(0, CMND, 32'h0, 4'd2, 5'd5);
        model_mem[5] = 64'h0123_4567_DEAD_BEEF;
        model_saddr  = 5'd5;
        checks++;
        if (stat_code !== 3'd1) begin errors++; $display("[TB] FAIL write_busy: got %0d want 1", stat_code); end
        wait_ready(0, n);
        checks++;
        if (n !== 1) begin errors++; $display("[TB] FAIL write_cycles: got %0d want 1", n); end
        checks++;
        if (mem_q[5*NB +: NB] !== 64'h0123_4567_DEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL write_entry5: got %h want 01234567deadbeef", mem_q[5*NB +: NB]);
        end
        checks++;
        if (first_bad(mem_q, pack_model()) >= 0) begin
            errors++;
            $display("[TB] FAIL write_other_entries: entry %0d differs", first_bad(mem_q, pack_model()));
        end
        csr_read(0, STAT, rd);
        checks++;
        if (rd !== 32'h0200_0005) begin errors++; $display("[TB] FAIL write_stat_word: got %h want 02000005", rd); end
    endtask

    task automatic test_read();
        int n;
        logic [31:0] rd;
        csr_write(0, DATA, 32'h0, 4'd0, 5'd0);
        csr_write(0, DATA + 11'd1, 32'h0, 4'd0, 5'd0);
        csr_read(0, DATA, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL read_clear: got %h want 0", rd); end
        csr_write(0, CMND, 32'h0, 4'd1, 5'd5);
        checks++;
        if (stat_code !== 3'd1) begin errors++; $display("[TB] FAIL read_busy: got %0d want 1", stat_code); end
        wait_ready(0, n);
        checks++;
        if (n !== 1) begin errors++; $display("[TB] FAIL read_cycles: got %0d want 1", n); end
        csr_read(0, DATA, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL read_dreg0: got %h want deadbeef", rd); end
        csr_read(0, DATA + 11'd1, rd);
        checks++;
        if (rd !== 32'h0123_4567) begin errors++; $display("[TB] FAIL read_dreg1: got %h want 01234567", rd); end
        model_dreg[0] = 32'hDEAD_BEEF;
        model_dreg[1] = 32'h0123_4567;
    endtask

    task automatic test_init();
        int n;
        int bad;
        logic [31:0] rd;
        csr_write(0, DATA, 32'h1111_1111, 4'd0, 5'd0);
        csr_write(0, DATA + 11'd1, 32'h2222_2222, 4'd0, 5'd0);
        model_dreg[0] = 32'h1111_1111;
        model_dreg[1] = 32'h2222_2222;
        csr_write(0, CMND, 32'h0, 4'd3, 5'd0);
        checks++;
        if (stat_code !== 3'd1) begin errors++; $display("[TB] FAIL init_busy: got %0d want 1", stat_code); end
        csr_write(0, CMND, 32'h0, 4'd2, 5'd9);
        checks++;
        if (stat_code !== 3'd1 || stat_addr !== 5'd0) begin
            errors++;
            $display("[TB] FAIL init_cmd_ignored: got code %0d addr %0d want 1/0", stat_code, stat_addr);
        end
        csr_write(0, DATA, 32'hFFFF_FFFF, 4'd0, 5'd0);
        wait_ready(0, n);
        checks++;
        if (n + 2 !== NE) begin errors++; $display("[TB] FAIL init_cycles: got %0d want %0d", n + 2, NE); end
        for (int i = 0; i < NE; i++) model_mem[i] = 64'h2222_2222_1111_1111;
        model_saddr = 5'd0;
        bad = first_bad(mem_q, pack_model());
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL init_fill entry %0d: got %h want 2222222211111111", bad, mem_q[bad*NB +: NB]);
        end
        checks++;
        if (stat_code !== 3'd0 || stat_addr !== 5'd0) begin
            errors++;
            $display("[TB] FAIL init_done: got code %0d addr %0d want 0/0", stat_code, stat_addr);
        end
        csr_read(0, DATA, rd);
        checks++;
        if (rd !== 32'h1111_1111) begin errors++; $display("[TB] FAIL init_dwrite_ignored: got %h want 11111111", rd); end
    endtask

    task automatic test_reset_op();
        int n;
        int bad;
        logic [4:0] ca;
        ca = 5'($urandom_range(0, NE - 1));
        csr_write(0, DATA, $urandom, 4'd0, 5'd0);
        csr_write(0, CMND, 32'h0, 4'd2, ca);
        wait_ready(0, n);
        csr_write(0, CMND, 32'h0, 4'd4, 5'd7);
        wait_ready(0, n);
        checks++;
        if (n !== 1) begin errors++; $display("[TB] FAIL resetop_cycles: got %0d want 1", n); end
        bad = first_bad(mem_q, rst_dat);
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL resetop_image entry %0d: got %h want %h", bad, mem_q[bad*NB +: NB], rst_dat[bad*NB +: NB]);
        end
        for (int i = 0; i < NE; i++) model_mem[i] = img(i);
        csr_read(0, DATA, model_dreg[0]);
        model_saddr = 5'd7;
        model_code  = 3'd0;
    endtask

    task automatic test_random();
        int n, kind, k, bad, exp_n;
        logic [3:0] op;
        logic [4:0] ca;
        logic [10:0] a;
        logic [31:0] v, rd;
        logic [2:0] exp_code;
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 11);
            if (kind <= 2) begin
                k = $urandom_range(0, 1);
                v = $urandom;
                csr_write(0, DATA + 11'(k), v, 4'($urandom), 5'($urandom));
                model_dreg[k] = v;
            end else if (kind == 3) begin
                case ($urandom_range(0, 4))
                    0:       a = STAT;
                    1:       a = 11'h453;
                    2:       a = 11'h455;
                    3:       a = 11'h462;
                    default: a = 11'h45F;
                endcase
                csr_write(0, a, $urandom, 4'($urandom_range(1, 4)), 5'($urandom));
            end else begin
                case (kind)
                    4, 5:    op = 4'd2;
                    6, 7:    op = 4'd1;
                    8:       op = 4'd0;
                    9:       op = 4'($urandom_range(5, 15));
                    10:      op = 4'd4;
                    default: op = 4'd3;
                endcase
                ca = 5'($urandom_range(0, NE - 1));
                exp_n = (op == 4'd3) ? NE : 1;
                exp_code = 3'd0;
                case (op)
                    4'd0: ;
                    4'd1: begin
                        model_dreg[0] = model_mem[ca][31:0];
                        model_dreg[1] = model_mem[ca][63:32];
                    end
                    4'd2: model_mem[ca] = {model_dreg[1], model_dreg[0]};
                    4'd3: for (int i = 0; i < NE; i++) model_mem[i] = {model_dreg[1], model_dreg[0]};
                    4'd4: for (int i = 0; i < NE; i++) model_mem[i] = img(i);
                    default: exp_code = 3'd3;
                endcase
                model_code  = exp_code;
                model_saddr = ca;
                csr_write(0, CMND, $urandom, op, ca);
                checks++;
                if (stat_code !== 3'd1) begin
                    errors++;
                    $display("[TB] FAIL rand_busy it=%0d op=%0d: got %0d want 1", it, op, stat_code);
                end
                wait_ready(0, n);
                checks++;
                if (n !== exp_n) begin
                    errors++;
                    $display("[TB] FAIL rand_cycles it=%0d op=%0d: got %0d want %0d", it, op, n, exp_n);
                end
                checks++;
                if (stat_code !== model_code || stat_addr !== model_saddr) begin
                    errors++;
                    $display("[TB] FAIL rand_status it=%0d op=%0d: got %0d/%0d want %0d/%0d",
                             it, op, stat_code, stat_addr, model_code, model_saddr);
                end
            end
            bad = first_bad(mem_q, pack_model());
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("[TB] FAIL rand_mem it=%0d entry %0d: got %h want %h", it, bad, mem_q[bad*NB +: NB], model_mem[bad]);
            end
            for (int j = 0; j < 2; j++) begin
                csr_read(0, DATA + 11'(j), rd);
                checks++;
                if (rd !== model_dreg[j]) begin
                    errors++;
                    $display("[TB] FAIL rand_dreg%0d it=%0d: got %h want %h", j, it, rd, model_dreg[j]);
                end
            end
            csr_read(0, STAT, rd);
            checks++;
            if (rd !== model_status()) begin
                errors++;
                $display("[TB] FAIL rand_stat_word it=%0d: got %h want %h", it, rd, model_status());
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int n, bad;
        logic [31:0] d0, d1, rd;
        d0 = $urandom;
        d1 = $urandom;
        csr_write(0, DATA, d0, 4'd0, 5'd0);
        csr_write(0, DATA + 11'd1, d1, 4'd0, 5'd0);
        csr_write(0, CMND, 32'h0, 4'd3, 5'd3);
        repeat (10) @(negedge clk);
        checks++;
        if (mem_q[0 +: NB] !== {d1, d0} || mem_q[10*NB +: NB] !== model_mem[10]) begin
            errors++;
            $display("[TB] FAIL midfill_progress: got e0 %h e10 %h want %h %h", mem_q[0 +: NB], mem_q[10*NB +: NB], {d1, d0}, model_mem[10]);
        end
        #2 rst_n = 1'b0;
        #1;
        bad = first_bad(mem_q, rst_dat);
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL midfill_image entry %0d: got %h want %h", bad, mem_q[bad*NB +: NB], rst_dat[bad*NB +: NB]);
        end
        checks++;
        if (stat_code !== 3'd0 || stat_addr !== 5'd0) begin
            errors++;
            $display("[TB] FAIL midfill_status: got %0d/%0d want 0/0", stat_code, stat_addr);
        end
        csr_read(0, DATA, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL midfill_dreg: got %h want 0", rd); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        csr_write(0, CMND, 32'h0, 4'd0, 5'd2);
        wait_ready(0, n);
        checks++;
        if (n !== 1 || stat_code !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midfill_recover: got cycles %0d code %0d want 1/0", n, stat_code);
        end
        model_saddr = 5'd2;
    endtask

    task automatic test_addr_error();
        int n, bad;
        logic [31:0] rd;
        csr_write(1, DATA, 32'hCAFE_0001, 4'd0, 5'd0);
        csr_write(1, DATA + 11'd1, 32'hCAFE_0002, 4'd0, 5'd0);
        csr_write(1, CMND, 32'h0, 4'd1, 5'd25);
        checks++;
        if (stat_code2 !== 3'd1) begin errors++; $display("[TB] FAIL err_busy: got %0d want 1", stat_code2); end
        wait_ready(1, n);
        checks++;
        if (n !== 1 || stat_code2 !== 3'd2 || stat_addr2 !== 5'd25) begin
            errors++;
            $display("[TB] FAIL err_addr_read: got cycles %0d code %0d addr %0d want 1/2/25", n, stat_code2, stat_addr2);
        end
        csr_read(1, DATA, rd);
        checks++;
        if (rd !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL err_dreg0: got %h want cafe0001", rd); end
        csr_read(1, DATA + 11'd1, rd);
        checks++;
        if (rd !== 32'hCAFE_0002) begin errors++; $display("[TB] FAIL err_dreg1: got %h want cafe0002", rd); end
        csr_write(1, CMND, 32'h0, 4'd2, 5'd20);
        wait_ready(1, n);
        checks++;
        if (stat_code2 !== 3'd2) begin errors++; $display("[TB] FAIL err_addr_write20: got %0d want 2", stat_code2); end
        bad = first_bad2(mem_q2, rst_dat2);
        checks++;
        if (bad >= 0) begin errors++; $display("[TB] FAIL err_mem_untouched entry %0d: got %h", bad, mem_q2[bad*NB +: NB]); end
        csr_write(1, CMND, 32'h0, 4'd9, 5'd3);
        wait_ready(1, n);
        repeat (3) @(negedge clk);
        checks++;
        if (stat_code2 !== 3'd3) begin errors++; $display("[TB] FAIL err_op: got %0d want 3", stat_code2); end
        csr_read(1, STAT, rd);
        checks++;
        if (rd[31:29] !== 3'd3) begin errors++; $display("[TB] FAIL err_op_stat_field: got %0d want 3", rd[31:29]); end
        csr_write(1, CMND, 32'h0, 4'd0, 5'd4);
        wait_ready(1, n);
        checks++;
        if (n !== 1 || stat_code2 !== 3'd0 || stat_addr2 !== 5'd4) begin
            errors++;
            $display("[TB] FAIL err_nop_clear: got cycles %0d code %0d addr %0d want 1/0/4", n, stat_code2, stat_addr2);
        end
        csr_write(1, CMND, 32'h0, 4'd2, 5'd19);
        wait_ready(1, n);
        checks++;
        if (stat_code2 !== 3'd0 || mem_q2[19*NB +: NB] !== 64'hCAFE_0002_CAFE_0001) begin
            errors++;
            $display("[TB] FAIL err_write19: got code %0d entry %h want 0/cafe0002cafe0001", stat_code2, mem_q2[19*NB +: NB]);
        end
        csr_write(1, DATA, 32'h0, 4'd0, 5'd0);
        csr_write(1, DATA + 11'd1, 32'h0, 4'd0, 5'd0);
        csr_write(1, CMND, 32'h0, 4'd1, 5'd18);
        wait_ready(1, n);
        csr_read(1, DATA + 11'd1, rd);
        checks++;
        if (rd !== img2(18)[63:32]) begin errors++; $display("[TB] FAIL err_read18: got %h want %h", rd, img2(18)[63:32]); end
    endtask

    initial begin
        for (int i = 0; i < NE; i++) rst_dat[i*NB +: NB] = img(i);
        for (int i = 0; i < NE2; i++) rst_dat2[i*NB +: NB] = img2(i);
        $display("[TB] starting");
        test_reset();
        test_write();
        test_read();
        test_init();
        test_reset_op();
        test_random();
        test_reset_mid_fill();
        test_addr_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
